// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO stack: op encoding and pointer sizing.
package lifo_pkg;

    // Operation codes decoded from {push, pop}
    localparam logic [1:0] OP_IDLE    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    // Address width for a DEPTH-entry array, never narrower than one bit
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// Stack storage: register array with one synchronous write port and one combinational read port.
module lifo_mem #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array has no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with replace, peek, occupancy flags and sticky error flags.
module lifo_stack_param
    import lifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         Rst_n,
    input  logic                         EN,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             dataIn,
    output logic [WIDTH-1:0]             dataOut,
    output logic                         dout_valid,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = ptr_width(DEPTH);

    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             dv_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    // Flags and peek follow the registered count directly
    assign EMPTY       = (count == '0);
    assign FULL        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(AF_LEVEL));
    assign raddr       = EMPTY ? '0 : AW'(count - CW'(1));
    assign top         = EMPTY ? '0 : rdata;

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (dataIn),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Operation decode; clr wins over push/pop, nothing moves while EN is low
    always_comb begin
        count_nxt = count;
        dout_nxt  = dataOut;
        dv_nxt    = 1'b0;
        ovf_nxt   = overflow;
        unf_nxt   = underflow;
        we        = 1'b0;
        waddr     = AW'(count);
        if (EN) begin
            if (clr) begin
                count_nxt = '0;
                ovf_nxt   = 1'b0;
                unf_nxt   = 1'b0;
            end else begin
                case ({push, pop})
                    OP_PUSH: begin
                        if (FULL) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            we        = 1'b1;
                            count_nxt = count + CW'(1);
                        end
                    end
                    OP_POP: begin
                        if (EMPTY) begin
                            unf_nxt = 1'b1;
                        end else begin
                            dout_nxt  = rdata;
                            dv_nxt    = 1'b1;
                            count_nxt = count - CW'(1);
                        end
                    end
                    OP_REPLACE: begin
                        we = 1'b1;
                        if (EMPTY) begin
                            count_nxt = CW'(1);
                        end else begin
                            // Overwrite the current top in place; occupancy unchanged
                            waddr    = raddr;
                            dout_nxt = rdata;
                            dv_nxt   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count      <= '0;
            dataOut    <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_nxt;
            dataOut    <= dout_nxt;
            dout_valid <= dv_nxt;
            overflow   <= ovf_nxt;
            underflow  <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench for lifo_stack_param: directed plan plus random traffic against a queue model.
module tb_lifo_stack_param;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AF_LEVEL = 3;
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             clr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             dout_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_dv;
    logic             m_ovf;
    logic             m_unf;

    lifo_stack_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .Rst_n       (rst_n),
        .EN          (en),
        .clr         (clr),
        .push        (push),
        .pop         (pop),
        .dataIn      (data_in),
        .dataOut     (data_out),
        .dout_valid  (dout_valid),
        .top         (top),
        .count       (count),
        .EMPTY       (empty),
        .FULL        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = q.size();
        check({tag, ".count"}, 32'(count), n);
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        check({tag, ".afull"}, 32'(almost_full), 32'(n >= AF_LEVEL));
        check({tag, ".top"}, 32'(top), (n == 0) ? 32'd0 : 32'(q[n-1]));
        check({tag, ".dout"}, 32'(data_out), 32'(m_dout));
        check({tag, ".dv"}, 32'(dout_valid), 32'(m_dv));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // Stack semantics written directly from the operation rules
    task automatic model_step(input logic e, input logic c, input logic pu, input logic po,
                              input logic [WIDTH-1:0] d);
        m_dv = 1'b0;
        if (!e) return;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pu && po) begin
            if (q.size() == 0) begin
                q.push_back(d);
            end else begin
                m_dout = q[q.size()-1];
                m_dv   = 1'b1;
                q[q.size()-1] = d;
            end
        end else if (pu) begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else q.push_back(d);
        end else if (po) begin
            if (q.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_dout = q.pop_back();
                m_dv   = 1'b1;
            end
        end
    endtask

    // Drive one cycle (inputs set 1 time unit after an edge), then check 1 unit after the next edge
    task automatic step(input string tag, input logic e, input logic c, input logic pu,
                        input logic po, input logic [WIDTH-1:0] d);
        en      = e;
        clr     = c;
        push    = pu;
        pop     = po;
        data_in = d;
        @(posedge clk);
        model_step(e, c, pu, po, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] pat [4];
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1. fill, then overflow
        for (int i = 0; i < 4; i++) step("t1_push", 1'b1, 1'b0, 1'b1, 1'b0, pat[i]);
        step("t1_ovf", 1'b1, 1'b0, 1'b1, 1'b0, 8'hE5);
        check("t1_ovf_flag", 32'(overflow), 32'd1);
        check("t1_top_d4", 32'(top), 32'hD4);

        // 2. drain, then underflow
        for (int i = 3; i >= 0; i--) begin
            step("t2_pop", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
            check("t2_dout", 32'(data_out), 32'(pat[i]));
        end
        step("t2_unf", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("t2_dout_hold", 32'(data_out), 32'hA1);
        check("t2_unf_flag", 32'(underflow), 32'd1);

        // 3. replace on a non-empty stack
        step("t3_push", 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
        step("t3_push", 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        step("t3_repl", 1'b1, 1'b0, 1'b1, 1'b1, 8'h33);
        check("t3_repl_dout", 32'(data_out), 32'h22);
        check("t3_repl_top", 32'(top), 32'h33);
        step("t3_pop", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("t3_pop33", 32'(data_out), 32'h33);
        step("t3_pop", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("t3_pop11", 32'(data_out), 32'h11);

        // 4. replace on empty acts as push; clear sticky underflow first
        step("t4_clr", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step("t4_repl", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        check("t4_top", 32'(top), 32'h5A);
        check("t4_unf", 32'(underflow), 32'd0);

        // 5. overflow via full path, EN=0 holds, clr beats push
        step("t5_clr", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step("t5_push", 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        step("t5_push4", 1'b1, 1'b0, 1'b1, 1'b0, 8'h63);
        step("t5_ovf", 1'b1, 1'b0, 1'b1, 1'b0, 8'h64);
        step("t5_hold", 1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
        step("t5_hold", 1'b0, 1'b0, 1'b0, 1'b1, 8'h98);
        check("t5_hold_ovf", 32'(overflow), 32'd1);
        step("t5_clr_push", 1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
        check("t5_clr_count", 32'(count), 32'd0);
        step("t5_pop_after_clr", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        // 6. async reset between edges with a live pop result
        step("t6_push", 1'b1, 1'b0, 1'b1, 1'b0, 8'h81);
        step("t6_push", 1'b1, 1'b0, 1'b1, 1'b0, 8'h82);
        step("t6_pop", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        en = 1'b0; pop = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6_async");
        @(posedge clk);
        #1;
        check_all("t6_in_reset");
        rst_n = 1'b1;
        step("t6_unf", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        check("t6_unf_flag", 32'(underflow), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic e, c, pu, po;
            e  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 24) == 0);
            pu = 1'($urandom);
            po = 1'($urandom);
            step("rand", e, c, pu, po, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/lifo_stack_param.md
Name: lifo_stack_param

Overview:
- Parametrised synchronous LIFO stack; next generation of the team's 4x4 stack.
- Adds generic WIDTH/DEPTH, separate push/pop strobes with a same-cycle replace operation, and a peek port.
- Adds occupancy count, almost-full flag, sticky overflow/underflow errors and a synchronous flush.
- Sits between a producer/consumer pair as a local return/context stack; single clock domain.

Parameters:
- WIDTH, 4, data word width in bits (>=1)
- DEPTH, 4, number of entries (>=2; power of two not required)
- AF_LEVEL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH)

Ports:
- clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- EN  in  1  global enable; when 0, no state changes except from Rst_n
- clr  in  1  synchronous flush: empties the stack and clears error flags (gated by EN)
- push  in  1  write dataIn onto the top
- pop  in  1  remove the top entry and present it on dataOut
- dataIn  in  WIDTH  push data
- dataOut  out  WIDTH  popped word, registered
- dout_valid  out  1  one-cycle pulse: dataOut holds a popped word
- top  out  WIDTH  peek of current top entry; 0 when empty
- count  out  $clog2(DEPTH+1)  current occupancy
- EMPTY  out  1  count==0
- FULL  out  1  count==DEPTH
- almost_full  out  1  count>=AF_LEVEL
- overflow  out  1  sticky: push rejected while FULL
- underflow  out  1  sticky: pop rejected while EMPTY

Behaviour:
- Reset (Rst_n=0, async):
  - count=0, EMPTY=1, FULL=0, almost_full=0.
  - dataOut=0, dout_valid=0, overflow=0, underflow=0, top=0.
  - Memory contents are not reset (don't-care); top is forced to 0 while EMPTY.
- All other updates occur on the rising clk edge and only when EN=1.
- EN=0: state holds; dout_valid=0.
- Priority: clr > push/pop.
  - clr=1: count->0, overflow/underflow->0, dout_valid=0; push/pop are ignored that cycle.
- Operations, decoded from {push,pop} when clr=0:
  - 00 idle: dout_valid=0.
  - 10 push:
    - if !FULL: mem[count]<=dataIn, count+1.
    - if FULL: no write, overflow<=1, count unchanged.
  - 01 pop:
    - if !EMPTY: dataOut<=mem[count-1], dout_valid=1, count-1.
    - if EMPTY: underflow<=1, dout_valid=0, dataOut holds.
  - 11 replace:
    - if !EMPTY: dataOut<=mem[count-1], dout_valid=1, mem[count-1]<=dataIn, count unchanged. Legal when FULL; no overflow.
    - if EMPTY: behaves as push only (write mem[0], count=1), dout_valid=0, no underflow.
- Latency:
  - dataOut/dout_valid are valid the cycle after the pop edge.
  - dout_valid is high for exactly one cycle per accepted pop/replace.
  - dataOut holds its last value otherwise.
- Flags: EMPTY, FULL, almost_full and top are derived from registered count and memory. They reflect the post-edge state with no extra cycle of lag.
- Width rules:
  - count is wide enough to hold DEPTH.
  - Memory index is $clog2(DEPTH) bits.
  - No wrap-around: count saturates at 0 and DEPTH by rejection, never by modulo.
- Sticky errors remain set until clr or reset; they do not block further operations.
- Reset mid-operation: async clear regardless of clk/EN; any in-flight pop result is lost and dout_valid=0 immediately.

Decomposition:
- Shared package lifo_pkg:
  - op encoding constants (OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE).
  - helper function for pointer width ($clog2 wrapper, min 1).
- Sub-module lifo_mem:
  - WIDTH x DEPTH register array.
  - One synchronous write port, one combinational read port at address count-1.
  - No reset on the array.
- Top level holds the count, the op decode, the flags and the output registers.

Test Plan (WIDTH=8, DEPTH=4, AF_LEVEL=3):
1. Reset then push A1,B2,C3,D4.
   - count 1..4; almost_full rises after C3; FULL after D4.
   - A 5th push of E5 sets overflow=1 with count=4 and top=D4.
2. From full, pop x4.
   - dataOut D4,C3,B2,A1 each one cycle after its pop, with dout_valid pulses; EMPTY=1 after the last.
   - A 5th pop sets underflow=1, dout_valid=0, dataOut stays A1.
3. Push 11,22, then push+pop with dataIn=33.
   - dataOut=22, dout_valid=1, count=2, top=33.
   - Next pop returns 33, then 11.
4. Empty stack, push+pop with dataIn=5A.
   - count=1, top=5A, dout_valid=0, underflow=0.
5. Push 3 words, set overflow via the full path, then clr=1 with push=1.
   - count=0, EMPTY=1, overflow=0, no write; EN=0 cycles in between leave all state unchanged.
6. Push 2 words, assert Rst_n=0 between clock edges.
   - count/flags/dataOut clear immediately, without waiting for a clk edge.
   - After release, pop raises underflow.
